game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
- Top-level game sequencer for the flappy-bird datapath.
- Generates the slow physics-tick enable and conditions the raw flap button into one press per tick.
- Runs the READY/PLAYING/DEAD/OVER state machine, keeps current and high score, and issues a one-cycle physics reset on restart.
- Sits between the input/pipe logic and the bird physics block; the VGA renderer reads its state and score outputs.

Parameters:
- TICK_DIV, 1048576, clk cycles per physics tick (>=2).
- DEAD_HOLD, 32, physics ticks spent in DEAD before OVER (>=1).
- SCORE_W, 8, width of score and high-score counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- flap_btn  input  1  raw, asynchronous flap button level
- bird_alive  input  1  alive flag from the bird physics block
- pipe_collision  input  1  level, bird overlaps a pipe
- pipe_passed  input  1  one-cycle pulse, bird cleared a pipe
- phys_tick  output  1  one-cycle physics update enable
- flap_out  output  1  flap request, valid only in a phys_tick cycle
- phys_reset  output  1  one-cycle reset pulse to the physics block
- state  output  2  0=READY 1=PLAYING 2=DEAD 3=OVER
- score  output  SCORE_W  current score
- high_score  output  SCORE_W  best score since reset

Behaviour:
- Reset values:
  - state=READY; score=0; high_score=0.
  - phys_tick=0, flap_out=0, phys_reset=0.
  - Tick counter, dead timer, sync flops and flap_pend cleared.
- Input conditioning:
  - flap_btn passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - A press sets flap_pend 3 cycles after flap_btn rises.
  - A held button produces only one press.
- Tick generator:
  - Counter cnt runs 0..TICK_DIV-1 and wraps.
  - phys_tick=1 in the cycle cnt==TICK_DIV-1, only in READY or PLAYING; it is registered.
  - cnt is forced to 0 on reset and on restart.
- Flap latch:
  - flap_pend is set by a press in READY or PLAYING.
  - In a phys_tick cycle, flap_out=flap_pend and flap_pend clears.
  - A press in the same cycle as the tick is held for the next tick, not dropped.
  - Presses in DEAD are ignored and not latched.
- State machine:
  - READY -> PLAYING when bird_alive==1.
  - PLAYING -> DEAD when pipe_collision==1 or bird_alive==0.
  - DEAD -> OVER after DEAD_HOLD ticks. The timer counts internal tick events even though phys_tick is suppressed.
  - OVER -> READY on a detected press. That cycle asserts phys_reset for exactly one cycle, clears score, cnt and flap_pend, and does not latch the press as a flap.
- Score:
  - +1 on pipe_passed only in PLAYING; saturates at 2^SCORE_W-1.
  - If pipe_passed and pipe_collision are high in the same cycle, collision wins and there is no increment.
- High score:
  - On the PLAYING->DEAD transition, high_score updates to score if score>high_score.
  - A pipe_passed in the transition cycle does not count.
- Quiet states: DEAD and OVER emit no phys_tick and no flap_out.
- Reset mid-game: all state is lost, high_score included; the block returns to READY with no phys_reset pulse (the physics block shares reset).

Decomposition:
- game_pkg holds:
  - state enum: ST_READY, ST_PLAYING, ST_DEAD, ST_OVER with the encodings above;
  - default TICK_DIV and DEAD_HOLD;
  - screen constants 480 and bird height 32, shared with physics.
- One sub-module, tick_gen: parameterised divider with enable and sync clear, outputting a one-cycle tick.
- Synchronizer, edge detect, FSM and score logic stay in game_controller.

Test Plan (TICK_DIV=4, DEAD_HOLD=3, SCORE_W=8):
1. Reset for 2 cycles, then idle 12 cycles -> phys_tick pulses every 4th cycle, state=0, score=0, flap_out=0, phys_reset=0.
2. flap_btn held high for 20 cycles in READY -> exactly one flap_out=1, coinciding with the first phys_tick at least 3 cycles after the rise; bird_alive=1 -> state=1 next cycle.
3. In PLAYING, pulse pipe_passed 3 times, then pipe_passed and pipe_collision together:
   - score=3, state=2, high_score=3;
   - phys_tick stops;
   - state=3 after 12 cycles.
4. In OVER, press flap:
   - phys_reset high for exactly 1 cycle;
   - state=0, score=0, high_score stays 3;
   - first phys_tick 4 cycles after phys_reset;
   - flap_out=0 on that tick.
5. Force score to 255 via 260 pipe_passed pulses in PLAYING -> score stays 255. Press during DEAD -> no flap_out after restart.
6. Assert reset mid-PLAYING with score=5 and flap_pend set -> next cycle state=0, score=0, high_score=0, no flap_out on the following tick.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types and constants for the flappy-bird datapath.
// Consumers: game_controller, tick_gen, physics and renderer blocks.
package game_pkg;

   typedef enum logic [1:0] {
      ST_READY   = 2'd0,
      ST_PLAYING = 2'd1,
      ST_DEAD    = 2'd2,
      ST_OVER    = 2'd3
   } game_state_t;

   localparam int unsigned TICK_DIV_DEF  = 1048576;
   localparam int unsigned DEAD_HOLD_DEF = 32;

   // Geometry shared with the bird physics block.
   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned BIRD_H   = 32;

   // Physics ticks and flap presses are only honoured while the bird is in play.
   function automatic logic is_live(input game_state_t s);
      return (s == ST_READY) || (s == ST_PLAYING);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick_o is registered and high for the one cycle in which the count is DIV-1.
// Latency: clr_i forces the count to 0 on the next edge, so the first tick lands DIV cycles after the clear cycle.
module tick_gen
   import game_pkg::*;
#(
   parameter int unsigned DIV = TICK_DIV_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Decoding the next count keeps the tick flop aligned with cnt_q == LAST.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= en_i && !clr_i && (cnt_d == LAST);
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/game_controller.sv
// Game sequencer: physics tick, one-flap-per-tick conditioning, READY/PLAYING/DEAD/OVER FSM, score keeping.
// Latency: a button press reaches flap_pend 3 cycles after the raw rise; phys_reset fires in the press cycle while OVER.
module game_controller
   import game_pkg::*;
#(
   parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
   parameter int unsigned DEAD_HOLD = DEAD_HOLD_DEF,
   parameter int unsigned SCORE_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flap_btn,
   input  logic               bird_alive,
   input  logic               pipe_collision,
   input  logic               pipe_passed,
   output logic               phys_tick,
   output logic               flap_out,
   output logic               phys_reset,
   output logic [1:0]         state,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score
);

   localparam int unsigned DW = $clog2(DEAD_HOLD + 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_HOLD - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic                sync1_q, sync2_q, sync3_q;
   logic                press, live, restart, tick_evt;
   game_state_t         state_q, state_d;
   logic [SCORE_W-1:0]  score_q, score_d, hs_q, hs_d;
   logic [DW-1:0]       dead_q, dead_d;
   logic                pend_q, pend_d;

   tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (1'b1),
      .clr_i   (restart),
      .tick_o  (tick_evt)
   );

   assign press      = sync2_q && !sync3_q;
   assign live       = is_live(state_q);
   assign restart    = (state_q == ST_OVER) && press;
   assign phys_tick  = tick_evt && live;
   assign flap_out   = phys_tick && pend_q;
   assign phys_reset = restart;
   assign state      = state_q;
   assign score      = score_q;
   assign high_score = hs_q;

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      hs_d    = hs_q;
      dead_d  = dead_q;
      pend_d  = pend_q;
      // Set after clear: a press landing on a tick waits for the following tick.
      if (phys_tick) pend_d = 1'b0;
      if (press && live) pend_d = 1'b1;
      case (state_q)
         ST_READY: begin
            if (bird_alive) state_d = ST_PLAYING;
         end
         ST_PLAYING: begin
            if (pipe_collision || !bird_alive) begin
               state_d = ST_DEAD;
               dead_d  = '0;
               if (score_q > hs_q) hs_d = score_q;
            end else if (pipe_passed && (score_q != SCORE_MAX)) begin
               score_d = score_q + 1'b1;
            end
         end
         ST_DEAD: begin
            // The hold timer runs on the ungated tick even though phys_tick is quiet.
            if (tick_evt) begin
               if (dead_q == DEAD_LAST) state_d = ST_OVER;
               else                     dead_d  = dead_q + 1'b1;
            end
         end
         ST_OVER: begin
            if (press) begin
               state_d = ST_READY;
               score_d = '0;
               pend_d  = 1'b0;
            end
         end
         default: state_d = ST_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         state_q <= ST_READY;
         score_q <= '0;
         hs_q    <= '0;
         dead_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         sync1_q <= flap_btn;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         state_q <= state_d;
         score_q <= score_d;
         hs_q    <= hs_d;
         dead_q  <= dead_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller with TICK_DIV=4, DEAD_HOLD=3, SCORE_W=8.
// Stimulus queues expected events; a negedge monitor pops them on state changes, flaps and phys_reset pulses.
module tb_game_controller;

   logic       clk = 1'b0;
   logic       reset, flap_btn, bird_alive, pipe_collision, pipe_passed;
   logic       phys_tick, flap_out, phys_reset;
   logic [1:0] state;
   logic [7:0] score, high_score;

   typedef struct {
      logic [1:0] st;
      logic [7:0] sc;
      logic [7:0] hs;
      logic       fl;
      logic       pr;
      int         cyc;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;
   int  last_rst = -1;
   int  tick_cnt = 0;

   game_controller #(.TICK_DIV(4), .DEAD_HOLD(3), .SCORE_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .flap_btn       (flap_btn),
      .bird_alive     (bird_alive),
      .pipe_collision (pipe_collision),
      .pipe_passed    (pipe_passed),
      .phys_tick      (phys_tick),
      .flap_out       (flap_out),
      .phys_reset     (phys_reset),
      .state          (state),
      .score          (score),
      .high_score     (high_score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] st, input logic [7:0] sc, input logic [7:0] hs,
                       input logic fl, input logic pr, input int c);
      ev_t e;
      e.st = st; e.sc = sc; e.hs = hs; e.fl = fl; e.pr = pr; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         pipe_passed = 1'b1; step(1);
         pipe_passed = 1'b0; step(1);
      end
   endtask

   task automatic sync_tick();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step(1);
         seen = phys_tick;
      end
      chk("tick_sync_timeout", seen, 1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) last_rst = cyc;
   end

   initial begin : monitor
      int         ref_cyc;
      int         ref_delta;
      logic [1:0] prev_st;
      ev_t        e;
      ref_cyc   = 0;
      ref_delta = 3;
      prev_st   = 2'd0;
      forever begin
         @(negedge clk);
         if (last_rst == cyc) begin
            ref_cyc   = cyc;
            ref_delta = 3;
            prev_st   = state;
         end else begin
            if (phys_tick) begin
               tick_cnt++;
               chk("tick_spacing", cyc - ref_cyc, ref_delta);
               ref_cyc   = cyc;
               ref_delta = 4;
            end
            if (phys_reset) begin
               ref_cyc   = cyc;
               ref_delta = 4;
            end
            if (state == 2'd2 || state == 2'd3) begin
               chk("quiet_tick", phys_tick, 0);
               chk("quiet_flap", flap_out, 0);
            end
            if (flap_out) chk("flap_without_tick", phys_tick, 1);
            if (state != prev_st || flap_out || phys_reset) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_event actual=st%0d/sc%0d/hs%0d/fl%0d/pr%0d required=none (cycle %0d)",
                           state, score, high_score, flap_out, phys_reset, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("ev_state", state, e.st);
                  chk("ev_score", score, e.sc);
                  chk("ev_high_score", high_score, e.hs);
                  chk("ev_flap_out", flap_out, e.fl);
                  chk("ev_phys_reset", phys_reset, e.pr);
                  if (e.cyc >= 0) chk("ev_cycle", cyc, e.cyc);
               end
            end
            prev_st = state;
         end
      end
   end

   initial begin
      reset = 1'b1; flap_btn = 1'b0; bird_alive = 1'b0;
      pipe_collision = 1'b0; pipe_passed = 1'b0;

      // 1: reset values, then idle READY ticking every 4th cycle
      step(2);
      chk("rst_state", state, 0);
      chk("rst_score", score, 0);
      chk("rst_high_score", high_score, 0);
      chk("rst_phys_tick", phys_tick, 0);
      chk("rst_flap_out", flap_out, 0);
      chk("rst_phys_reset", phys_reset, 0);
      reset = 1'b0;
      step(12);
      chk("idle_tick_count", tick_cnt, 3);

      // 2: held button gives a single flap on the tick at cycle 17; alive -> PLAYING
      push(2'd0, 8'd0, 8'd0, 1'b1, 1'b0, 17);
      push(2'd1, 8'd0, 8'd0, 1'b0, 1'b0, 35);
      flap_btn = 1'b1; step(20);
      flap_btn = 1'b0; bird_alive = 1'b1; step(2);

      // 3: three pipes, then pass+collision together; DEAD holds three internal ticks
      push(2'd2, 8'd3, 8'd3, 1'b0, 1'b0, 43);
      push(2'd3, 8'd3, 8'd3, 1'b0, 1'b0, 54);
      pulses(3);
      chk("score_after_3", score, 3);
      pipe_passed = 1'b1; pipe_collision = 1'b1; step(1);
      pipe_passed = 1'b0; pipe_collision = 1'b0; bird_alive = 1'b0;
      chk("dead_state", state, 2);
      chk("dead_score", score, 3);
      chk("dead_high_score", high_score, 3);
      step(12);
      chk("over_state", state, 3);

      // 4: restart from OVER
      push(2'd3, 8'd3, 8'd3, 1'b0, 1'b1, 57);
      push(2'd0, 8'd0, 8'd3, 1'b0, 1'b0, 58);
      flap_btn = 1'b1; step(8);
      flap_btn = 1'b0;
      chk("restart_state", state, 0);
      chk("restart_score", score, 0);
      chk("restart_high_score", high_score, 3);

      // 5: score saturation, press in DEAD ignored
      push(2'd1, 8'd0, 8'd3, 1'b0, 1'b0, 64);
      bird_alive = 1'b1; step(2);
      push(2'd2, 8'd255, 8'd255, 1'b0, 1'b0, -1);
      push(2'd3, 8'd255, 8'd255, 1'b0, 1'b0, -1);
      pulses(260);
      chk("score_saturated", score, 255);
      pipe_collision = 1'b1; step(1);
      pipe_collision = 1'b0; bird_alive = 1'b0; flap_btn = 1'b1; step(4);
      flap_btn = 1'b0; step(12);
      chk("over_state_2", state, 3);
      push(2'd3, 8'd255, 8'd255, 1'b0, 1'b1, -1);
      push(2'd0, 8'd0, 8'd255, 1'b0, 1'b0, -1);
      flap_btn = 1'b1; step(6);
      flap_btn = 1'b0; step(12);
      chk("ready_after_sat", state, 0);
      chk("high_score_sat", high_score, 255);

      // 6: hard reset mid-PLAYING with a flap pending
      push(2'd1, 8'd0, 8'd255, 1'b0, 1'b0, -1);
      bird_alive = 1'b1; step(2);
      pulses(5);
      chk("score_5", score, 5);
      sync_tick();
      flap_btn = 1'b1; step(3);
      reset = 1'b1; flap_btn = 1'b0; bird_alive = 1'b0; step(1);
      chk("midrst_state", state, 0);
      chk("midrst_score", score, 0);
      chk("midrst_high_score", high_score, 0);
      chk("midrst_phys_reset", phys_reset, 0);
      chk("midrst_flap_out", flap_out, 0);
      reset = 1'b0;
      step(10);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
